hdlverifier_capture_ctrl: RTL

//  Sequences one capture-and-readout cycle of the HDL Verifier data-capture path: fills the capture RAM on trigger,

---
 rtl/hdlverifier_capture_ctrl_pkg.sv | 20 ++
 rtl/hdlverifier_capture_ctrl_if.sv | 26 ++
 rtl/hdlverifier_capture_ctrl_rise_detect.sv | 16 +
 rtl/hdlverifier_capture_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/hdlverifier_capture_ctrl_pkg.sv
// Shared types and sizing helpers for the capture/readout sequencer.
package hdlverifier_capture_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARMED    = 3'd1,
      ST_CAPTURE  = 3'd2,
      ST_READY    = 3'd3,
      ST_ISSUE    = 3'd4,
      ST_WAIT_ACK = 3'd5,
      ST_WAIT_END = 3'd6,
      ST_DONE     = 3'd7
   } state_t;

   // Timer counts 0 .. timeout-1, so it needs clog2(timeout) bits (at least one).
   function automatic int timer_width(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/hdlverifier_capture_ctrl_if.sv
// Trigger/sample, capture-RAM write and JTAG chunk handshake signals of the sequencer.
interface hdlverifier_capture_ctrl_if #(parameter int ADDR_WIDTH = 5);
   logic                  arm;
   logic                  abort;
   logic                  trigger;
   logic                  data_valid;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] waddr;
   logic                  chunk_req;
   logic                  newChunk;
   logic [ADDR_WIDTH-1:0] chunkSize;
   logic                  rdy_send;
   logic                  capture_done;
   logic                  busy;
   logic                  error;

   modport master (
      input  arm, abort, trigger, data_valid, chunk_req, rdy_send,
      output wr_en, waddr, newChunk, chunkSize, capture_done, busy, error
   );

   modport slave (
      output arm, abort, trigger, data_valid, chunk_req, rdy_send,
      input  wr_en, waddr, newChunk, chunkSize, capture_done, busy, error
   );
endinterface

// File: rtl/hdlverifier_capture_ctrl_rise_detect.sv
// Registered rising-edge detector; the previous value resets low.
module hdlverifier_capture_ctrl_rise_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic rise
);
   logic din_q;

   always_ff @(posedge clk) begin
      if (!reset_n) din_q <= 1'b0;
      else          din_q <= din;
   end

   assign rise = din & ~din_q;
endmodule

// File: rtl/hdlverifier_capture_ctrl.sv
// Capture-and-readout sequencer: fills the capture RAM after a trigger, then hands it
// to the JTAG read datapath one chunk at a time.
module hdlverifier_capture_ctrl
   import hdlverifier_capture_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = 5,
   parameter int CHUNK_SIZE  = 8,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   hdlverifier_capture_ctrl_if.master bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int TW    = timer_width(ACK_TIMEOUT);

   localparam logic [ADDR_WIDTH:0]   DEPTH_W    = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] CHUNK_W    = ADDR_WIDTH'(CHUNK_SIZE);
   localparam logic [TW-1:0]         TIMER_LAST = TW'(ACK_TIMEOUT - 1);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_nxt;
   logic [ADDR_WIDTH-1:0] chunk_size_q, chunk_size_nxt;
   logic [ADDR_WIDTH:0]   words_left_q, words_left_nxt;
   logic [TW-1:0]         timer_q, timer_nxt;
   logic                  capture_done_q, capture_done_nxt;
   logic                  error_q, error_nxt;
   logic                  req_rise;

   // The last chunk carries whatever is left; words_left only reaches DEPTH
   // when it exceeds CHUNK_SIZE, so the truncation in the else branch is safe.
   function automatic logic [ADDR_WIDTH-1:0] next_chunk(input logic [ADDR_WIDTH:0] left);
      return (left >= {1'b0, CHUNK_W}) ? CHUNK_W : left[ADDR_WIDTH-1:0];
   endfunction

   hdlverifier_capture_ctrl_rise_detect u_req_rise (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (bus.chunk_req),
      .rise   (req_rise)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         waddr_q        <= '0;
         chunk_size_q   <= CHUNK_W;
         words_left_q   <= DEPTH_W;
         timer_q        <= '0;
         capture_done_q <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state          <= state_nxt;
         waddr_q        <= waddr_nxt;
         chunk_size_q   <= chunk_size_nxt;
         words_left_q   <= words_left_nxt;
         timer_q        <= timer_nxt;
         capture_done_q <= capture_done_nxt;
         error_q        <= error_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      waddr_nxt        = waddr_q;
      chunk_size_nxt   = chunk_size_q;
      words_left_nxt   = words_left_q;
      timer_nxt        = timer_q;
      capture_done_nxt = capture_done_q;
      error_nxt        = error_q;

      if (bus.abort) begin
         state_nxt        = ST_IDLE;
         capture_done_nxt = 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.arm) begin
                  state_nxt        = ST_ARMED;
                  waddr_nxt        = '0;
                  words_left_nxt   = DEPTH_W;
                  error_nxt        = 1'b0;
                  capture_done_nxt = 1'b0;
               end
            end
            ST_ARMED: begin
               // The qualifying sample itself lands at address 0.
               if (bus.trigger && bus.data_valid) begin
                  state_nxt = ST_CAPTURE;
                  waddr_nxt = waddr_q + 1'b1;
               end
            end
            ST_CAPTURE: begin
               if (bus.data_valid) begin
                  if (waddr_q == LAST_ADDR) begin
                     state_nxt        = ST_READY;
                     waddr_nxt        = '0;
                     capture_done_nxt = 1'b1;
                  end else begin
                     waddr_nxt = waddr_q + 1'b1;
                  end
               end
            end
            ST_READY: begin
               if (req_rise) begin
                  state_nxt      = ST_ISSUE;
                  chunk_size_nxt = next_chunk(words_left_q);
               end
            end
            ST_ISSUE: begin
               state_nxt = ST_WAIT_ACK;
               timer_nxt = '0;
            end
            ST_WAIT_ACK: begin
               if (!bus.rdy_send) begin
                  state_nxt = ST_WAIT_END;
               end else if (timer_q == TIMER_LAST) begin
                  state_nxt        = ST_IDLE;
                  error_nxt        = 1'b1;
                  capture_done_nxt = 1'b0;
               end else begin
                  timer_nxt = timer_q + 1'b1;
               end
            end
            ST_WAIT_END: begin
               if (bus.rdy_send) begin
                  words_left_nxt = words_left_q - {1'b0, chunk_size_q};
                  state_nxt      = (words_left_nxt == '0) ? ST_DONE : ST_READY;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign bus.wr_en        = bus.data_valid & ~bus.abort &
                             (((state == ST_ARMED) & bus.trigger) | (state == ST_CAPTURE));
   assign bus.waddr        = waddr_q;
   assign bus.newChunk     = (state == ST_ISSUE);
   assign bus.chunkSize    = chunk_size_q;
   assign bus.capture_done = capture_done_q;
   assign bus.busy         = (state == ST_ARMED)    || (state == ST_CAPTURE) ||
                             (state == ST_ISSUE)    || (state == ST_WAIT_ACK) ||
                             (state == ST_WAIT_END);
   assign bus.error        = error_q;
endmodule
